pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic inter-stage pipeline register for the MIPS pipeline (F/D, D/E, E/M, M/W), replacing per-stage hand-written registers.
- Carries PC, instruction, branch-delay flag, merged ExcCode, a valid bit and a parametrised sideband payload.
- Uses a valid/ready handshake with a one-entry skid buffer, so downstream stalls reach upstream through a registered ready.
- Handles exception/interrupt flush (bubble at handler PC) and ordinary flush (bubble keeping PC).

Parameters:
- PAYLOAD_W, 32: width of the extra stage-specific sideband bus (≥1).
- RESET_PC, 32'h0000_3000: PC presented by the bubble produced at reset.
- HANDLER_PC, 32'h0000_4180: PC presented by the bubble produced by req.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- req  in  1  exception/interrupt taken; flush to handler bubble.
- flush  in  1  ordinary flush; insert bubble, retain PC.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  registered; upstream may transfer when in_valid&in_ready.
- in_pc  in  32  PC of entry.
- in_instr  in  32  instruction word.
- in_bd  in  1  entry sits in a branch-delay slot.
- in_exc  in  5  ExcCode already raised by older stages (0 = none).
- local_exc  in  5  ExcCode raised by the producing stage this cycle (0 = none).
- in_payload  in  PAYLOAD_W  stage sideband.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts; out_ready=0 is a stall.
- out_pc, out_instr, out_bd, out_exc, out_payload  out  32/32/1/5/PAYLOAD_W  registered entry.

Behaviour:
- Priority each edge: reset > req > flush > handshake.
- Reset (reset=0):
  - out_valid=0, out_pc=RESET_PC, out_instr=0, out_bd=0, out_exc=0, out_payload=0.
  - Skid buffer emptied; in_ready=1 on the next cycle.
- req=1: same as reset, except out_pc=HANDLER_PC.
- flush=1 (req=0):
  - out_valid=0, out_instr=0, out_bd=0, out_exc=0, out_payload=0; out_pc holds its value.
  - Skid buffer emptied; in_ready=1.
- Capture merge, applied on every capture into main or skid:
  - exc = (in_exc!=0) ? in_exc : local_exc; the older exception wins.
  - If exc!=0, the entry is still captured with its instr; exceptions are not filtered here.
- Handshake (no flush):
  - Main register advances when out_ready=1 or out_valid=0.
  - If it advances and the skid is full: main ← skid, skid empties.
  - If it advances and the skid is empty: main ← input when in_valid&in_ready, else out_valid ← 0 with data fields held.
  - If main does not advance and in_valid&in_ready: input goes to the skid, skid becomes full.
- in_ready = !skid_full, registered. Maximum two entries held; no input is lost when in_ready=1 during a stall.
- Latency:
  - One cycle input→output with the skid empty.
  - Throughput one entry per cycle under continuous out_ready=1.
- Data fields (pc/instr/bd/exc/payload) hold their value while out_valid=1 and out_ready=0.
- Simultaneous events:
  - req and flush together → req behaviour.
  - A flush in the same cycle as a transfer discards the transferred entry.
  - reset mid-stall drops both entries.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, adds three output ports, all cleared by reset:
  - perf_stall_cnt (32): cycles with out_valid=1 and out_ready=0, saturating at 32'hFFFF_FFFF.
  - perf_bubble_cnt (32): cycles with out_valid=0, excluding the reset cycle itself, saturating at 32'hFFFF_FFFF.
  - perf_flush_cnt (16): req|flush events, wrapping.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg:
  - EXC_W=5.
  - ExcCode constants: EXC_NONE=0, EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYSCALL=8, EXC_RI=10, EXC_OV=12.
  - RESET_PC and HANDLER_PC defaults.
  - Packed struct stage_entry_t {pc, instr, bd, exc}.
- One sub-module: pipe_stage_entry_reg (a single loadable entry register with clear-to-bubble), instantiated twice for main and skid.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release → out_valid=0, out_pc=32'h3000, out_exc=0, in_ready=1.
- Stream: in_pc=3000,3004,3008, out_ready=1 → outputs appear one cycle later in order with out_valid=1 and no gaps.
- Stall/skid: out_ready=0 while 3000 is at the output and 3004 is offered:
  - 3004 goes to the skid and in_ready=0 next cycle.
  - After out_ready=1: 3000, then 3004, then 3008 in order.
- Exception merge: in_exc=4 with local_exc=10 → out_exc=4; in_exc=0 with local_exc=12 → out_exc=12.
- Flush paths:
  - req=1 while the skid is full → next cycle out_valid=0, out_pc=32'h4180, in_ready=1, skid entry gone.
  - flush=1 with out_pc=32'h3010 → out_valid=0, out_pc stays 32'h3010.
- Perf (PIPE_STAGE_PERF_EN): 5 stall cycles then 1 req → perf_stall_cnt=5, perf_flush_cnt=1.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the MIPS pipeline stage
//               registers: ExcCode values, default PCs, entry layout and
//               the older-exception-wins merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int          EXC_W              = 5;

    localparam logic [4:0]  EXC_NONE           = 5'd0;
    localparam logic [4:0]  EXC_INT            = 5'd0;
    localparam logic [4:0]  EXC_ADEL           = 5'd4;
    localparam logic [4:0]  EXC_ADES           = 5'd5;
    localparam logic [4:0]  EXC_SYSCALL        = 5'd8;
    localparam logic [4:0]  EXC_RI             = 5'd10;
    localparam logic [4:0]  EXC_OV             = 5'd12;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic             bd;
        logic [EXC_W-1:0] exc;
    } stage_entry_t;

    localparam int ENTRY_W = $bits(stage_entry_t);

    // An exception raised by an older stage always outranks a local one.
    function automatic logic [EXC_W-1:0] merge_exc(input logic [EXC_W-1:0] older_exc,
                                                    input logic [EXC_W-1:0] local_exc);
        return (older_exc != EXC_NONE) ? older_exc : local_exc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_entry_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_entry_reg
// Description : One loadable pipeline entry (pc/instr/bd/exc + payload).
//               Clearing turns it into a bubble; the PC is either replaced
//               with a supplied value or kept.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_entry_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk,
    input  logic                 i_clear,
    input  logic                 i_clear_pc_en,
    input  logic [31:0]          i_clear_pc,
    input  logic                 i_load,
    input  logic [ENTRY_W-1:0]   i_entry,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic [ENTRY_W-1:0]   o_entry,
    output logic [PAYLOAD_W-1:0] o_payload
);

    stage_entry_t         r_entry;
    logic [PAYLOAD_W-1:0] r_payload;

    // Clear to bubble has priority over a load; data holds otherwise.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_entry.instr <= '0;
            r_entry.bd    <= 1'b0;
            r_entry.exc   <= EXC_NONE;
            r_payload     <= '0;
            if (i_clear_pc_en) begin
                r_entry.pc <= i_clear_pc;
            end
        end else if (i_load) begin
            r_entry   <= stage_entry_t'(i_entry);
            r_payload <= i_payload;
        end
    end

    assign o_entry   = r_entry;
    assign o_payload = r_payload;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic inter-stage pipeline register with valid/ready
//               handshake and a one-entry skid buffer, so the ready seen by
//               the upstream stage is registered. Supports exception flush
//               (bubble at handler PC) and ordinary flush (bubble, PC kept).
//               Optional performance counters: define PIPE_STAGE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          PAYLOAD_W  = 32,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_instr,
    input  logic                 in_bd,
    input  logic [EXC_W-1:0]     in_exc,
    input  logic [EXC_W-1:0]     local_exc,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_instr,
    output logic                 out_bd,
    output logic [EXC_W-1:0]     out_exc,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_bubble_cnt,
    output logic [15:0]          perf_flush_cnt,
`endif
    output logic [PAYLOAD_W-1:0] out_payload
);

    logic                 r_out_valid;
    logic                 r_skid_full;

    logic                 w_kill;
    logic                 w_clear;
    logic                 w_clear_pc_en;
    logic [31:0]          w_clear_pc;
    logic                 w_in_fire;
    logic                 w_advance;
    logic                 w_main_load;
    logic                 w_skid_load;
    stage_entry_t         w_in_entry;
    stage_entry_t         w_main_d;
    stage_entry_t         w_main_q;
    stage_entry_t         w_skid_q;
    logic [PAYLOAD_W-1:0] w_main_pl_d;
    logic [PAYLOAD_W-1:0] w_main_pl_q;
    logic [PAYLOAD_W-1:0] w_skid_pl_q;

    assign w_kill        = req | flush;
    assign w_clear       = !reset | w_kill;
    assign w_clear_pc_en = !reset | req;
    assign w_clear_pc    = !reset ? RESET_PC : HANDLER_PC;

    // Ready is the registered skid state, so it never depends on out_ready.
    assign in_ready  = !r_skid_full;
    assign w_in_fire = in_valid & !r_skid_full;
    assign w_advance = out_ready | !r_out_valid;

    assign w_in_entry.pc    = in_pc;
    assign w_in_entry.instr = in_instr;
    assign w_in_entry.bd    = in_bd;
    assign w_in_entry.exc   = merge_exc(in_exc, local_exc);

    // Skid contents are older than the current input, so they drain first.
    assign w_main_d    = r_skid_full ? w_skid_q    : w_in_entry;
    assign w_main_pl_d = r_skid_full ? w_skid_pl_q : in_payload;
    assign w_main_load = w_advance & (r_skid_full | w_in_fire);
    assign w_skid_load = !w_advance & w_in_fire;

    pipe_stage_entry_reg #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_main (
        .clk           (clk),
        .i_clear       (w_clear),
        .i_clear_pc_en (w_clear_pc_en),
        .i_clear_pc    (w_clear_pc),
        .i_load        (w_main_load),
        .i_entry       (w_main_d),
        .i_payload     (w_main_pl_d),
        .o_entry       (w_main_q),
        .o_payload     (w_main_pl_q)
    );

    pipe_stage_entry_reg #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk           (clk),
        .i_clear       (w_clear),
        .i_clear_pc_en (w_clear_pc_en),
        .i_clear_pc    (w_clear_pc),
        .i_load        (w_skid_load),
        .i_entry       (w_in_entry),
        .i_payload     (in_payload),
        .o_entry       (w_skid_q),
        .o_payload     (w_skid_pl_q)
    );

    // Occupancy tracking: reset > req > flush > handshake.
    always_ff @(posedge clk) begin
        if (!reset || w_kill) begin
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= r_skid_full | w_in_fire;
            r_skid_full <= 1'b0;
        end else if (w_in_fire) begin
            r_skid_full <= 1'b1;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_pc      = w_main_q.pc;
    assign out_instr   = w_main_q.instr;
    assign out_bd      = w_main_q.bd;
    assign out_exc     = w_main_q.exc;
    assign out_payload = w_main_pl_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_bubble_cnt;
    logic [15:0] r_perf_flush_cnt;

    // Stall and bubble counters saturate; flush event counter wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_stall_cnt  <= '0;
            r_perf_bubble_cnt <= '0;
            r_perf_flush_cnt  <= '0;
        end else begin
            if (r_out_valid && !out_ready && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if (!r_out_valid && (r_perf_bubble_cnt != 32'hFFFF_FFFF)) begin
                r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
            end
            if (w_kill) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 16'd1;
            end
        end
    end

    assign perf_stall_cnt  = r_perf_stall_cnt;
    assign perf_bubble_cnt = r_perf_bubble_cnt;
    assign perf_flush_cnt  = r_perf_flush_cnt;
`endif

endmodule
`default_nettype wire
